calc_1: RTL and testbench

CALC_1 -- requirements
Module: calc_1

---
 rtl/calc_1_pkg.sv | 81 ++++++++
 rtl/calc_1_port.sv | 83 ++++++++
 rtl/calc_1.sv | 79 +++++++
 tb/tb_calc_1.sv | 211 +++++++++++++++++++++
 4 files changed

// File: rtl/calc_1_pkg.sv
`default_nettype none
// ============================================================================
// Module   : calc_1_pkg
// Purpose  : Shared encodings, widths and the per-port ALU function used by
//            the calc_1 request/response calculator.
// Contents : DATA_W/CMD_W/RESP_W/SHAMT_W widths, cmd_e / resp_e / state_e
//            enums, result_t struct, alu() combinational helper.
// Revision : 1.0 - initial release
// ============================================================================
package calc_1_pkg;

  localparam int DATA_W  = 32;
  localparam int CMD_W   = 4;
  localparam int RESP_W  = 2;
  localparam int SHAMT_W = 5;

  typedef enum logic [CMD_W-1:0] {
    CMD_NOP = 4'd0,
    CMD_ADD = 4'd1,
    CMD_SUB = 4'd2,
    CMD_SHL = 4'd5,
    CMD_SHR = 4'd6
  } cmd_e;

  typedef enum logic [RESP_W-1:0] {
    RESP_NONE = 2'd0,
    RESP_OK   = 2'd1,
    RESP_ERR  = 2'd2
  } resp_e;

  typedef enum logic {
    ST_IDLE     = 1'b0,
    ST_WAIT_OP2 = 1'b1
  } state_e;

  typedef struct packed {
    logic [DATA_W-1:0] data;
    resp_e             resp;
  } result_t;

  // Any failing operation (overflow, underflow, unknown opcode) returns zero
  // data so downstream logic never sees a partial result.
  function automatic result_t alu(input logic [CMD_W-1:0]  cmd,
                                  input logic [DATA_W-1:0] op1,
                                  input logic [DATA_W-1:0] op2);
    result_t         res;
    logic [DATA_W:0] sum;
    sum      = {1'b0, op1} + {1'b0, op2};
    res.data = '0;
    res.resp = RESP_ERR;
    case (cmd)
      CMD_ADD: begin
        if (!sum[DATA_W]) begin
          res.data = sum[DATA_W-1:0];
          res.resp = RESP_OK;
        end
      end
      CMD_SUB: begin
        if (op2 <= op1) begin
          res.data = op1 - op2;
          res.resp = RESP_OK;
        end
      end
      CMD_SHL: begin
        res.data = op1 << op2[SHAMT_W-1:0];
        res.resp = RESP_OK;
      end
      CMD_SHR: begin
        res.data = op1 >> op2[SHAMT_W-1:0];
        res.resp = RESP_OK;
      end
      default: begin
        res.data = '0;
        res.resp = RESP_ERR;
      end
    endcase
    return res;
  endfunction

endpackage
`default_nettype wire

// File: rtl/calc_1_port.sv
`default_nettype none
// ============================================================================
// Module   : calc_port
// Purpose  : One independent calculator port: two-state FSM capturing the
//            command and operand 1, then operand 2, producing a one-cycle
//            registered result/response pulse.
// Ports    : clk     - rising-edge clock
//            rst     - synchronous active-high reset
//            i_cmd   - command ([0:3], bit 0 = MSB)
//            i_data  - operand ([0:31], bit 0 = MSB)
//            o_data  - result, nonzero only in the response cycle
//            o_resp  - response code, nonzero only in the response cycle
// Revision : 1.0 - initial release
// ============================================================================
module calc_port
  import calc_1_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic [0:CMD_W-1]  i_cmd,
  input  logic [0:DATA_W-1] i_data,
  output logic [0:DATA_W-1] o_data,
  output logic [0:RESP_W-1] o_resp
);

  state_e            r_state;
  state_e            w_state_next;
  logic [CMD_W-1:0]  r_cmd;
  logic [DATA_W-1:0] r_op1;
  logic [DATA_W-1:0] r_data;
  resp_e             r_resp;
  logic              w_capture;
  logic              w_fire;
  result_t           w_res;

  always_comb begin
    w_state_next = r_state;
    w_capture    = 1'b0;
    w_fire       = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (i_cmd != '0) begin
          w_state_next = ST_WAIT_OP2;
          w_capture    = 1'b1;
        end
      end
      ST_WAIT_OP2: begin
        // The command input is deliberately ignored here; operand 2 is
        // consumed and the port is free again on the very next edge.
        w_state_next = ST_IDLE;
        w_fire       = 1'b1;
      end
      default: w_state_next = ST_IDLE;
    endcase
  end

  // Operand 2 is used straight off the input bus, never stored.
  assign w_res = alu(r_cmd, r_op1, i_data);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_cmd   <= '0;
      r_op1   <= '0;
      r_data  <= '0;
      r_resp  <= RESP_NONE;
    end else begin
      r_state <= w_state_next;
      if (w_capture) begin
        r_cmd <= i_cmd;
        r_op1 <= i_data;
      end
      // Outputs self-clear so the result is a single-cycle pulse.
      r_data <= w_fire ? w_res.data : '0;
      r_resp <= w_fire ? w_res.resp : RESP_NONE;
    end
  end

  assign o_data = r_data;
  assign o_resp = r_resp;

endmodule
`default_nettype wire

// File: rtl/calc_1.sv
`default_nettype none
// ============================================================================
// Module   : calc_1
// Purpose  : Four-port request/response calculator. Each port is an
//            independent calc_port; there is no shared arbitration.
// Ports    : out_data1..4  - per-port result ([0:31], bit 0 = MSB)
//            out_resp1..4  - per-port response (0 none, 1 ok, 2 error)
//            c_clk         - rising-edge clock
//            reqN_cmd_in   - per-port command ([0:3])
//            reqN_data_in  - per-port operand ([0:31])
//            reset         - [1:7] synchronous reset, any bit set resets
// Revision : 1.0 - initial release
// ============================================================================
module calc_1
  import calc_1_pkg::*;
(
  output logic [0:DATA_W-1] out_data1,
  output logic [0:DATA_W-1] out_data2,
  output logic [0:DATA_W-1] out_data3,
  output logic [0:DATA_W-1] out_data4,
  output logic [0:RESP_W-1] out_resp1,
  output logic [0:RESP_W-1] out_resp2,
  output logic [0:RESP_W-1] out_resp3,
  output logic [0:RESP_W-1] out_resp4,
  input  logic              c_clk,
  input  logic [0:CMD_W-1]  req1_cmd_in,
  input  logic [0:DATA_W-1] req1_data_in,
  input  logic [0:CMD_W-1]  req2_cmd_in,
  input  logic [0:DATA_W-1] req2_data_in,
  input  logic [0:CMD_W-1]  req3_cmd_in,
  input  logic [0:DATA_W-1] req3_data_in,
  input  logic [0:CMD_W-1]  req4_cmd_in,
  input  logic [0:DATA_W-1] req4_data_in,
  input  logic [1:7]        reset
);

  logic w_rst;

  // Any asserted reset bit holds every port in reset.
  assign w_rst = |reset;

  calc_port u_port1 (
    .clk    (c_clk),
    .rst    (w_rst),
    .i_cmd  (req1_cmd_in),
    .i_data (req1_data_in),
    .o_data (out_data1),
    .o_resp (out_resp1)
  );

  calc_port u_port2 (
    .clk    (c_clk),
    .rst    (w_rst),
    .i_cmd  (req2_cmd_in),
    .i_data (req2_data_in),
    .o_data (out_data2),
    .o_resp (out_resp2)
  );

  calc_port u_port3 (
    .clk    (c_clk),
    .rst    (w_rst),
    .i_cmd  (req3_cmd_in),
    .i_data (req3_data_in),
    .o_data (out_data3),
    .o_resp (out_resp3)
  );

  calc_port u_port4 (
    .clk    (c_clk),
    .rst    (w_rst),
    .i_cmd  (req4_cmd_in),
    .i_data (req4_data_in),
    .o_data (out_data4),
    .o_resp (out_resp4)
  );

endmodule
`default_nettype wire

// File: tb/tb_calc_1.sv
`default_nettype none
// ============================================================================
// Module   : tb_calc_1
// Purpose  : Self-checking bench for calc_1. Directed stimulus pushes the
//            expected result of each command into a scoreboard tagged with
//            the cycle it must appear in; a negedge monitor compares every
//            port every cycle (zero when nothing is due).
// Revision : 1.0 - initial release
// ============================================================================
module tb_calc_1;

  logic        c_clk;
  logic [1:7]  reset;
  logic [0:3]  cmd [1:4];
  logic [0:31] dat [1:4];
  logic [0:31] od  [1:4];
  logic [0:1]  orsp[1:4];

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  typedef struct {
    int          port;
    int          due;
    logic [31:0] d;
    logic [1:0]  r;
    string       tag;
  } exp_t;

  exp_t sb[$];

  logic [31:0] mon_d  [1:4];
  logic [1:0]  mon_r  [1:4];
  string       mon_tag[1:4];

  calc_1 dut (
    .out_data1    (od[1]),
    .out_data2    (od[2]),
    .out_data3    (od[3]),
    .out_data4    (od[4]),
    .out_resp1    (orsp[1]),
    .out_resp2    (orsp[2]),
    .out_resp3    (orsp[3]),
    .out_resp4    (orsp[4]),
    .c_clk        (c_clk),
    .req1_cmd_in  (cmd[1]),
    .req1_data_in (dat[1]),
    .req2_cmd_in  (cmd[2]),
    .req2_data_in (dat[2]),
    .req3_cmd_in  (cmd[3]),
    .req3_data_in (dat[3]),
    .req4_cmd_in  (cmd[4]),
    .req4_data_in (dat[4]),
    .reset        (reset)
  );

  initial c_clk = 1'b0;
  always #5 c_clk = ~c_clk;

  always @(posedge c_clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h (cycle %0d)", tag, obs, expv, cyc);
    end
  endtask

  // Reference add for random operands: 33-bit sum, overflow -> error.
  function automatic logic [33:0] add_ref(input logic [31:0] a, input logic [31:0] b);
    logic [32:0] s;
    s = {1'b0, a} + {1'b0, b};
    if (s[32]) return {32'd0, 2'd2};
    return {s[31:0], 2'd1};
  endfunction

  // Every cycle after the first edge, each port must show either its due
  // scoreboard entry or all-zero outputs.
  always @(negedge c_clk) begin
    if (cyc >= 1) begin
      for (int p = 1; p <= 4; p++) begin
        mon_d[p]   = '0;
        mon_r[p]   = '0;
        mon_tag[p] = $sformatf("idle_p%0d", p);
      end
      while (sb.size() > 0 && sb[0].due <= cyc) begin
        exp_t e;
        e = sb.pop_front();
        mon_d[e.port]   = e.d;
        mon_r[e.port]   = e.r;
        mon_tag[e.port] = e.tag;
      end
      for (int p = 1; p <= 4; p++) begin
        chk({mon_tag[p], "_data"}, od[p], mon_d[p]);
        chk({mon_tag[p], "_resp"}, {30'd0, orsp[p]}, {30'd0, mon_r[p]});
      end
    end
  end

  // Called at a negedge; result is due two edges later. During the
  // operand-2 cycle the command bus carries junk that must be ignored.
  task automatic op(input int p, input logic [3:0] c, input logic [31:0] a,
                    input logic [31:0] b, input logic [31:0] ed,
                    input logic [1:0] er, input string tag);
    cmd[p] = c;
    dat[p] = a;
    sb.push_back('{port: p, due: cyc + 2, d: ed, r: er, tag: tag});
    @(negedge c_clk);
    cmd[p] = 4'hF;
    dat[p] = b;
    @(negedge c_clk);
    cmd[p] = 4'h0;
    dat[p] = '0;
  endtask

  logic [31:0] pa[1:4];
  logic [31:0] pb[1:4];
  logic [33:0] pe;

  initial begin
    reset = 7'h7F;
    for (int p = 1; p <= 4; p++) begin
      cmd[p] = 4'd1;
      dat[p] = $urandom;
    end
    repeat (3) @(negedge c_clk);
    reset = '0;
    for (int p = 1; p <= 4; p++) begin
      cmd[p] = 4'd0;
      dat[p] = '0;
    end

    // First cycle out of reset accepts a command; back-to-back issue.
    op(1, 4'd1, 32'h0000_0001, 32'h1FFF_FFFF, 32'h2000_0000, 2'd1, "add_small");
    op(1, 4'd1, 32'h1FFF_FFFF, 32'h1FFF_FFFF, 32'h3FFF_FFFE, 2'd1, "add_same");
    op(1, 4'd1, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000, 2'd2, "add_ovf");
    op(1, 4'd1, 32'hFFFF_FFFE, 32'h0000_0001, 32'hFFFF_FFFF, 2'd1, "add_max");
    op(1, 4'd2, 32'd1, 32'd15, 32'd0, 2'd2, "sub_under");
    op(1, 4'd2, 32'd15, 32'd1, 32'd14, 2'd1, "sub_ok");
    op(1, 4'd2, 32'd7, 32'd7, 32'd0, 2'd1, "sub_equal");
    op(1, 4'd3, 32'h1234_5678, 32'd9, 32'd0, 2'd2, "cmd3");
    op(1, 4'd4, 32'd1, 32'd1, 32'd0, 2'd2, "cmd4");
    op(1, 4'd15, 32'd5, 32'd5, 32'd0, 2'd2, "cmd15");
    op(1, 4'd5, 32'h8000_0001, 32'd0, 32'h8000_0001, 2'd1, "shl0");
    op(1, 4'd6, 32'hDEAD_BEEF, 32'd0, 32'hDEAD_BEEF, 2'd1, "shr0");
    op(1, 4'd5, 32'h0000_0003, 32'hFFFF_FFE4, 32'h0000_0030, 2'd1, "shl_low5");
    op(1, 4'd6, 32'hF000_0000, 32'd31, 32'h0000_0001, 2'd1, "shr31");

    for (int k = 1; k <= 30; k++) begin
      logic [31:0] v;
      v = 32'd1 << k;
      op(1, 4'd1, v, 32'd0, v, 2'd1, $sformatf("sweep_add_k%0d", k));
      op(1, 4'd5, v, 32'd1, 32'd1 << (k + 1), 2'd1, $sformatf("sweep_shl_k%0d", k));
      op(1, 4'd6, v, 32'd1, 32'd1 << (k - 1), 2'd1, $sformatf("sweep_shr_k%0d", k));
    end

    // No-op with random data on every port: monitor expects silence.
    repeat (2) begin
      for (int p = 1; p <= 4; p++) begin
        cmd[p] = 4'd0;
        dat[p] = $urandom;
      end
      @(negedge c_clk);
    end

    // Four concurrent, different adds completing in the same cycle.
    for (int p = 1; p <= 4; p++) begin
      pa[p] = $urandom;
      pb[p] = (p == 4) ? ~pa[p] + 32'd5 : ($urandom >> p);
      pe    = add_ref(pa[p], pb[p]);
      cmd[p] = 4'd1;
      dat[p] = pa[p];
      sb.push_back('{port: p, due: cyc + 2, d: pe[33:2], r: pe[1:0],
                     tag: $sformatf("par_add_p%0d", p)});
    end
    @(negedge c_clk);
    for (int p = 1; p <= 4; p++) begin
      cmd[p] = 4'd2;
      dat[p] = pb[p];
    end
    @(negedge c_clk);
    for (int p = 1; p <= 4; p++) begin
      cmd[p] = 4'd0;
      dat[p] = '0;
    end
    op(2, 4'd2, 32'd100, 32'd1, 32'd99, 2'd1, "p2_sub");
    op(3, 4'd5, 32'd1, 32'd31, 32'h8000_0000, 2'd1, "p3_shl31");
    op(4, 4'd6, 32'h8000_0000, 32'd4, 32'h0800_0000, 2'd1, "p4_shr4");

    // Reset via bit 1 only while port 1 waits for operand 2: no response.
    cmd[1] = 4'd1;
    dat[1] = 32'd5;
    @(negedge c_clk);
    cmd[1] = 4'd0;
    dat[1] = 32'd7;
    reset  = 7'b100_0000;
    @(negedge c_clk);
    reset  = '0;
    op(1, 4'd1, 32'd10, 32'd20, 32'd30, 2'd1, "post_reset_add");

    repeat (3) @(negedge c_clk);
    chk("scoreboard_empty", sb.size(), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
